// File: rtl/ha_pkg.sv
// Shared definitions for the half-adder accumulator slice.
//   ha_state_e : accumulator FSM states (IDLE, ACCUM, DONE)
//   SUM_W_DEF / ACC_W_DEF : default field widths
//   beat_w()   : width of one incoming beat value ({carry, sum})
package ha_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } ha_state_e;

  localparam int SUM_W_DEF = 3;
  localparam int ACC_W_DEF = 8;

  // A beat is {carry, sum}: the carry sits just above the sum field.
  function automatic int beat_w(input int sum_w);
    return sum_w + 1;
  endfunction

endpackage

// File: rtl/ha_beat_counter.sv
// Loadable up-counter tracking beats accepted in the current block.
// Ports:
//   clk, rst   : clock, async active-high reset
//   clr        : synchronous clear to 0 (highest priority)
//   load       : synchronous load of load_val
//   load_val   : value for load
//   inc        : increment enable
//   cnt        : current count
//   tc_next    : high when the next increment reaches COUNT_N
module ha_beat_counter #(
  parameter int COUNT_N = 4,
  parameter int CNT_W   = $clog2(COUNT_N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_next
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flagging one beat early lets the FSM leave ACCUM on the very edge
  // that accepts the final beat.
  assign tc_next = (cnt_q == CNT_W'(COUNT_N - 1));
  assign cnt     = cnt_q;

endmodule

// File: rtl/ha_accumulator.sv
// Accumulates COUNT_N {carry, sum} beats into an ACC_W-bit block total
// with a sticky overflow flag.
// Ports:
//   clk, rst             : clock, async active-high reset
//   start                : begin a block (only honoured in IDLE)
//   in_valid / in_ready  : input beat handshake, fields sum / carry
//   out_valid / out_ready: final total handshake
//   acc_out, overflow    : running/final total and sticky wrap flag
//   beat_cnt             : beats accepted in the current block
//   busy                 : FSM not in IDLE
//   dbg_state            : raw FSM state for observation
// Handshake: a transfer happens on every rising edge where valid and ready
// are both high; ready/valid here depend only on registered state, and
// out_ready may be raised before out_valid.
module ha_accumulator
  import ha_pkg::*;
#(
  parameter int SUM_W   = SUM_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int COUNT_N = 4,
  parameter int CNT_W   = $clog2(COUNT_N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int BW = beat_w(SUM_W);

  ha_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             cnt_clr, cnt_inc, cnt_tc_next;
  logic [BW-1:0]    beat;
  logic [ACC_W:0]   add_ext;

  assign beat    = {carry, sum};
  // One extra bit catches the carry-out of the accumulator add.
  assign add_ext = {1'b0, acc_q} + (ACC_W + 1)'(beat);

  ha_beat_counter #(
    .COUNT_N (COUNT_N),
    .CNT_W   (CNT_W)
  ) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (cnt_inc),
    .cnt      (beat_cnt),
    .tc_next  (cnt_tc_next)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        // Last block's result stays visible until the next start.
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = add_ext[ACC_W-1:0];
          ovf_d   = ovf_q | add_ext[ACC_W];
          cnt_inc = 1'b1;
          if (cnt_tc_next) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ha_accumulator.sv
// Bench for ha_accumulator: two instances (ACC_W=8 and ACC_W=4) share one
// stimulus stream and are checked against an arithmetic model of the block
// total (overflow == the unbounded block total reached 2^ACC_W).
module tb_ha_accumulator;

  localparam int SUM_W   = 3;
  localparam int COUNT_N = 4;
  localparam int CNT_W   = $clog2(COUNT_N + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start, in_valid, carry, out_ready;
  logic [SUM_W-1:0] sum;

  logic             ir8, ov8, ovf8, busy8;
  logic [7:0]       acc8;
  logic [CNT_W-1:0] cnt8;
  logic [1:0]       st8;

  logic             ir4, ov4, ovf4, busy4;
  logic [3:0]       acc4;
  logic [CNT_W-1:0] cnt4;
  logic [1:0]       st4;

  ha_accumulator #(.SUM_W(SUM_W), .ACC_W(8), .COUNT_N(COUNT_N)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir8),
    .sum(sum), .carry(carry), .out_valid(ov8), .out_ready(out_ready),
    .acc_out(acc8), .overflow(ovf8), .beat_cnt(cnt8), .busy(busy8),
    .dbg_state(st8)
  );

  ha_accumulator #(.SUM_W(SUM_W), .ACC_W(4), .COUNT_N(COUNT_N)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir4),
    .sum(sum), .carry(carry), .out_valid(ov4), .out_ready(out_ready),
    .acc_out(acc4), .overflow(ovf4), .beat_cnt(cnt4), .busy(busy4),
    .dbg_state(st4)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];      // block totals (low 8 bits) awaiting output transfer

  int m_phase = 0;           // 0 = idle, 1 = collecting beats, 2 = result held
  int m_total = 0;           // unbounded sum of beats in current/last block
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_outputs();
    check("acc8",   acc8,  m_total % 256);
    check("ovf8",   ovf8,  m_total >= 256);
    check("cnt8",   cnt8,  m_cnt);
    check("rdy8",   ir8,   m_phase == 1);
    check("ov8",    ov8,   m_phase == 2);
    check("busy8",  busy8, m_phase != 0);
    check("acc4",   acc4,  m_total % 16);
    check("ovf4",   ovf4,  m_total >= 16);
    check("cnt4",   cnt4,  m_cnt);
    check("ov4",    ov4,   m_phase == 2);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_total = 0;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic st, input logic iv, input int s, input logic c,
                      input logic ordy);
    logic [7:0] e;
    start     = st;
    in_valid  = iv;
    sum       = SUM_W'(s);
    carry     = c;
    out_ready = ordy;
    case (m_phase)
      0: if (st) begin
           m_phase = 1;
           m_total = 0;
           m_cnt   = 0;
         end
      1: if (iv) begin
           m_total += s + (c ? (1 << SUM_W) : 0);
           m_cnt++;
           if (m_cnt == COUNT_N) begin
             m_phase = 2;
             exp_q.push_back(8'(m_total % 256));
           end
         end
      default: if (ordy) begin
           if (exp_q.size() == 0) begin
             check("sb_empty", 32'd1, 32'd0);
           end else begin
             e = exp_q.pop_front();
             check("sb_total8", acc8, e);
             check("sb_total4", acc4, e[3:0]);
           end
           m_phase = 0;
         end
    endcase
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  int vpat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    start = 0; in_valid = 0; sum = '0; carry = 0; out_ready = 0;
    #12;
    check_outputs();                // reset state
    rst = 0;

    // Block of 3, 11, 5, 15 back to back -> 0x22
    step(1, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0);
    step(0, 1, 3, 1, 0);
    step(0, 1, 5, 0, 0);
    step(0, 1, 7, 1, 0);
    check("tp1_acc8", acc8, 32'h22);
    check("tp1_ovf8", ovf8, 0);
    check("tp1_cnt8", cnt8, 4);
    step(0, 0, 0, 0, 1);

    // Four beats of 15: the 4-bit instance wraps to 12 with overflow
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 7, 1, 0);
    check("tp2_acc4", acc4, 12);
    check("tp2_ovf4", ovf4, 1);
    // Hold the result for 5 cycles, then release
    for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 1), 7, 1, 0);
    check("tp3_hold", acc4, 12);
    step(0, 0, 0, 0, 1);
    check("tp3_idle", busy4, 0);
    // Next start clears the sticky flag
    step(1, 0, 0, 0, 0);
    check("tp2_clr", ovf4, 0);

    // Gappy valid pattern with ignored start pulses during ACCUM
    for (int i = 0; i < 7; i++) step(i == 2, vpat[i][0], 1, 0, 0);
    check("tp4_done", ov8, 1);
    check("tp4_cnt", cnt8, 4);
    step(1, 0, 0, 0, 0);            // start during DONE: ignored
    step(0, 0, 0, 0, 1);
    // in_valid while idle: nothing accepted
    step(0, 1, 6, 1, 0);
    step(0, 1, 2, 0, 1);

    // Asynchronous reset after two beats
    step(1, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0);
    step(0, 1, 5, 1, 0);
    #3 rst = 1;
    #1;
    model_reset();
    check_outputs();
    #2 rst = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    check("tp5_acc8", acc8, 4);
    step(0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
